ext_unit_pipe: RTL and testbench



---
 rtl/ext_pkg.sv | 24 ++
 rtl/ext_core.sv | 46 ++++
 rtl/ext_unit_pipe.sv | 143 ++++++++++++++
 tb/tb_ext_unit_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the pipelined immediate extender.
//   MODE_W      - width of the mode select
//   EXT_OUT_W   - result width carried by ext_item_t
//   EXT_*       - mode codes (code 7 is illegal and flags out_err)
//   ext_item_t  - {err, data} payload held in the output and skid registers
package ext_pkg;

  localparam int MODE_W    = 3;
  localparam int EXT_OUT_W = 32;

  localparam logic [MODE_W-1:0] EXT_SIGN  = 3'd0;
  localparam logic [MODE_W-1:0] EXT_ZERO  = 3'd1;
  localparam logic [MODE_W-1:0] EXT_UPPER = 3'd2;
  localparam logic [MODE_W-1:0] EXT_WOFF  = 3'd3;
  localparam logic [MODE_W-1:0] EXT_BSIGN = 3'd4;
  localparam logic [MODE_W-1:0] EXT_BZERO = 3'd5;
  localparam logic [MODE_W-1:0] EXT_BROFF = 3'd6;

  typedef struct packed {
    logic                 err;
    logic [EXT_OUT_W-1:0] data;
  } ext_item_t;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational mode mux that extends / positions an IN_W-bit field
// to OUT_W bits.
//   mode_i   [MODE_W] - extension mode (ext_pkg codes)
//   data_i   [IN_W]   - raw field
//   result_o [OUT_W]  - extended result (0 for an illegal mode)
//   err_o             - 1 when mode_i is not a legal code
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [IN_W-1:0]   data_i,
  output logic [OUT_W-1:0]  result_o,
  output logic              err_o
);

  localparam int E = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_s;
  logic [OUT_W-1:0] zext_s;

  assign sext_s = {{E{data_i[IN_W-1]}}, data_i};
  assign zext_s = {{E{1'b0}}, data_i};

  // Mode mux; word-offset modes drop the bits shifted past OUT_W.
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (mode_i)
      EXT_SIGN:  result_o = sext_s;
      EXT_ZERO:  result_o = zext_s;
      EXT_UPPER: result_o = {data_i, {E{1'b0}}};
      EXT_WOFF:  result_o = zext_s << 2;
      EXT_BSIGN: result_o = {{(OUT_W-8){data_i[7]}}, data_i[7:0]};
      EXT_BZERO: result_o = {{(OUT_W-8){1'b0}}, data_i[7:0]};
      EXT_BROFF: result_o = sext_s << 2;
      default: begin
        result_o = '0;
        err_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: pipelined immediate extender with valid/ready on both sides,
// a registered output stage and a one-entry skid buffer. in_ready depends only
// on the skid state and rst, never on out_ready.
//   clk, rst (sync, active-high)
//   in_valid/in_ready/in_mode/in_data    - producer side
//   out_valid/out_ready/out_data/out_err - consumer side
// Build option EXT_PERF_CNT_EN adds acc_cnt (accepted items), stall_cnt
// (cycles with out_valid && !out_ready) and sticky err_seen (illegal mode
// accepted since the last rst).
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
`ifdef EXT_PERF_CNT_EN
  output logic [31:0]       acc_cnt,
  output logic [31:0]       stall_cnt,
  output logic              err_seen,
`endif
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_err
);

  // ext_item_t fixes the carried width, so OUT_W must match it.
  if (IN_W < 8 || IN_W >= OUT_W || OUT_W != EXT_OUT_W) begin : g_bad_params
    $fatal(1, "ext_unit_pipe: illegal IN_W/OUT_W combination");
  end

  ext_item_t out_q, out_d;
  ext_item_t skid_q, skid_d;
  logic      out_valid_q, out_valid_d;
  logic      skid_valid_q, skid_valid_d;
  ext_item_t new_s;
  logic      accept_s;
  logic      drain_s;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode_i   (in_mode),
    .data_i   (in_data),
    .result_o (new_s.data),
    .err_o    (new_s.err)
  );

  assign in_ready = !skid_valid_q && !rst;
  assign accept_s = in_valid && in_ready;
  assign drain_s  = out_valid_q && out_ready;

  // Output/skid steering. While the skid is full in_ready is low, so a drain
  // in that state never coincides with an accept.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (drain_s) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        out_d = new_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!out_valid_q) begin
      if (accept_s) begin
        out_d       = new_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_d       = new_s;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Pipeline state; rst discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_err   = out_q.err;

`ifdef EXT_PERF_CNT_EN
  logic [31:0] acc_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        err_seen_q;

  // Throughput / stall counters (wrap naturally) and sticky illegal-mode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
      err_seen_q  <= 1'b0;
    end else begin
      if (accept_s) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
      end
      if (out_valid_q && !out_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (accept_s && new_s.err) begin
        err_seen_q <= 1'b1;
      end
    end
  end

  assign acc_cnt   = acc_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign err_seen  = err_seen_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ext_unit_pipe.sv
module tb_ext_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
`ifdef EXT_PERF_CNT_EN
  logic [31:0] acc_cnt;
  logic [31:0] stall_cnt;
  logic        err_seen;
`endif

  int n_cmp;
  int n_fail;

  ext_unit_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
`ifdef EXT_PERF_CNT_EN
    .acc_cnt   (acc_cnt),
    .stall_cnt (stall_cnt),
    .err_seen  (err_seen),
`endif
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 3'd0; in_data = 16'h0000; out_ready = 1'b0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", out_err); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready); end
    rst = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_sign_zero();
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 3'd0; in_data = 16'h8001;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sign_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'hFFFF8001) begin n_fail++; $display("FAIL sign_data: got %h want FFFF8001", out_data); end
    in_mode = 3'd1; in_data = 16'h8001;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'h00008001) begin n_fail++; $display("FAIL zero_data: got %h want 00008001", out_data); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sz_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_modes();
    logic [2:0]  modes [5];
    logic [15:0] datas [5];
    logic [31:0] exps  [5];
    modes[0] = 3'd2; datas[0] = 16'h1234; exps[0] = 32'h12340000;
    modes[1] = 3'd3; datas[1] = 16'hFFFF; exps[1] = 32'h0003FFFC;
    modes[2] = 3'd6; datas[2] = 16'hFFFF; exps[2] = 32'hFFFFFFFC;
    modes[3] = 3'd4; datas[3] = 16'h12F0; exps[3] = 32'hFFFFFFF0;
    modes[4] = 3'd5; datas[4] = 16'h12F0; exps[4] = 32'h000000F0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_mode = modes[i]; in_data = datas[i];
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exps[i] || out_err !== 1'b0) begin
        n_fail++; $display("FAIL mode%0d: got v=%b d=%h e=%b want v=1 d=%h e=0", modes[i], out_valid, out_data, out_err, exps[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd1; in_data = 16'h00AA;  // A -> 000000AA
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_A: got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h000000AA) begin n_fail++; $display("FAIL bp_out_A: got v=%b d=%h want v=1 d=000000AA", out_valid, out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_B: got %b want 1", in_ready); end
    in_mode = 3'd0; in_data = 16'hBBBB;                   // B -> FFFFBBBB
    step();
    in_mode = 3'd2; in_data = 16'h00CC;                   // C -> 00CC0000
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_C%0d: got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h000000AA || out_err !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=000000AA", i, out_valid, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFBBBB) begin n_fail++; $display("FAIL bp_out_B: got v=%b d=%h want v=1 d=FFFFBBBB", out_valid, out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00CC0000) begin n_fail++; $display("FAIL bp_out_C: got v=%b d=%h want v=1 d=00CC0000", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 3'd7; in_data = 16'hABCD;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_err !== 1'b1) begin
      n_fail++; $display("FAIL illegal: got v=%b d=%h e=%b want v=1 d=00000000 e=1", out_valid, out_data, out_err);
    end
    in_mode = 3'd0; in_data = 16'h0001;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00000001 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL after_illegal: got v=%b d=%h e=%b want v=1 d=00000001 e=0", out_valid, out_data, out_err);
    end
`ifdef EXT_PERF_CNT_EN
    n_cmp++; if (err_seen !== 1'b1) begin n_fail++; $display("FAIL err_seen: got %b want 1", err_seen); end
`endif
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd1; in_data = 16'h0D0D;
    step();
    in_data = 16'h0E0E;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mf_full: got in_ready=%b want 0", in_ready); end
    in_valid = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mf_ready_rst: got %b want 0", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL mf_rst_out: got v=%b d=%h e=%b want 0/00000000/0", out_valid, out_data, out_err);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mf_ready_during: got %b want 0", in_ready); end
`ifdef EXT_PERF_CNT_EN
    n_cmp++; if (acc_cnt !== 32'd0) begin n_fail++; $display("FAIL mf_acc_cnt: got %0d want 0", acc_cnt); end
    n_cmp++; if (err_seen !== 1'b0) begin n_fail++; $display("FAIL mf_err_seen: got %b want 0", err_seen); end
`endif
    rst = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mf_ready_after: got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mf_stale%0d: got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
    in_valid = 1'b1; in_mode = 3'd5; in_data = 16'h0081;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00000081) begin n_fail++; $display("FAIL mf_fresh: got v=%b d=%h want v=1 d=00000081", out_valid, out_data); end
`ifdef EXT_PERF_CNT_EN
    n_cmp++; if (acc_cnt !== 32'd1) begin n_fail++; $display("FAIL mf_acc_one: got %0d want 1", acc_cnt); end
`endif
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_sign_zero();
    test_modes();
    test_back_to_back();
    test_illegal();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
